ysyx_ifu_linebuf: RTL

- Next-generation instruction fetch unit.
- Fetches a whole aligned line of LINE_WORDS 32-bit words with one AXI4 INCR read burst and keeps it in a single-line buffer.
- Sequential fetches that fall in the buffered line return without a bus transaction.
- Sits between the writeback/PC stage (request handshake) and the decode stage (instruction handshake); it owns a read-only AXI4 master port.

---
 rtl/ysyx_ifu_pkg.sv | 35 +++
 rtl/ysyx_ifu_linebuf_mem.sv | 62 ++++++
 rtl/ysyx_ifu_linebuf.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ysyx_ifu_pkg.sv
// Shared definitions for the line-buffer instruction fetch unit.
// Holds the IFU state encoding, the fixed AXI4 field values the unit
// drives or compares against, and helpers that size the line index and
// tag fields from the number of words per line.
package ysyx_ifu_pkg;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_IDLE,
        ST_LOOKUP,
        ST_AR,
        ST_R,
        ST_RESP
    } ifu_state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_WORD  = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // Word index width; kept at least one bit so a one-word line still
    // has a legal index port.
    function automatic int line_idx_w(input int line_words);
        return (line_words > 1) ? $clog2(line_words) : 1;
    endfunction

    // Byte-offset width of a whole line (word index plus byte-in-word bits).
    function automatic int line_off_w(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int line_tag_w(input int line_words);
        return 32 - line_off_w(line_words);
    endfunction

endpackage

// File: rtl/ysyx_ifu_linebuf_mem.sv
// Single-line instruction buffer storage.
// Ports:
//   clock, reset            : clock and synchronous active-high reset
//   wr_en, wr_idx, wr_data  : word write port (one word per cycle)
//   rd_idx, rd_data         : combinational word read
//   meta_we, meta_valid,
//   meta_tag                : load tag and valid bit at the end of a fill
//   inval                   : clear the valid bit
//   line_valid, line_tag    : current tag/valid state
module ysyx_ifu_linebuf_mem
    import ysyx_ifu_pkg::*;
#(
    parameter  int LINE_WORDS = 4,
    localparam int IDX_W      = line_idx_w(LINE_WORDS),
    localparam int TAG_W      = line_tag_w(LINE_WORDS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data,
    input  logic             meta_we,
    input  logic             meta_valid,
    input  logic [TAG_W-1:0] meta_tag,
    input  logic             inval,
    output logic             line_valid,
    output logic [TAG_W-1:0] line_tag
);

    logic [31:0] words [LINE_WORDS];

    // NOTE: the data array and tag carry no reset; the valid bit alone
    // guards them, which keeps the storage plain flops without reset muxes.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            words[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (meta_we) begin
            line_tag <= meta_tag;
        end
    end

    // A fill completion and an invalidate never coincide: invalidates
    // from the top are suppressed while a burst is in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            line_valid <= 1'b0;
        end else if (meta_we) begin
            line_valid <= meta_valid;
        end else if (inval) begin
            line_valid <= 1'b0;
        end
    end

    assign rd_data = words[rd_idx];

endmodule

// File: rtl/ysyx_ifu_linebuf.sv
// Instruction fetch unit with a single-line buffer.
// Fetches a whole aligned line with one AXI4 INCR burst and serves
// sequential fetches that fall in that line without touching the bus.
// Ports:
//   clock, reset                 : clock and synchronous active-high reset
//   req_valid/req_ready/req_pc   : PC request from the writeback/PC stage
//   flush                        : invalidate the buffered line
//   out_valid/out_ready/out_inst/
//   out_pc/out_err               : instruction handshake to decode
//   ar*/r*                       : read-only AXI4 master port
module ysyx_ifu_linebuf
    import ysyx_ifu_pkg::*;
#(
    parameter int          LINE_WORDS = 4,
    parameter logic [31:0] RESET_PC   = 32'h3000_0000,
    parameter logic [3:0]  AXI_ID     = 4'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_err,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    output logic [3:0]  arid,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic [3:0]  rid
);

    localparam int IDX_W = line_idx_w(LINE_WORDS);
    localparam int OFF_W = line_off_w(LINE_WORDS);
    localparam int TAG_W = line_tag_w(LINE_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    ifu_state_t state, state_next;

    logic [31:0]      pc;
    logic [IDX_W-1:0] pc_idx;
    logic [TAG_W-1:0] pc_tag;
    logic [IDX_W-1:0] beat_cnt;
    logic             err;
    logic             flush_pending;
    logic             overrun;

    logic [31:0]      rd_data;
    logic             line_valid;
    logic [TAG_W-1:0] line_tag;

    logic hit, beat, last_idx, beat_err, err_now, wr_en, bypass, burst_done;

    // Read id is not checked: only one burst is ever outstanding.
    logic unused_rid;
    assign unused_rid = ^rid;

    assign arid    = AXI_ID;
    assign arlen   = 8'(LINE_WORDS - 1);
    assign arsize  = SIZE_WORD;
    assign arburst = BURST_INCR;

    assign pc_idx = IDX_W'((pc >> 2) & 32'(LINE_WORDS - 1));
    assign pc_tag = pc[31:OFF_W];

    // A flush in the lookup cycle overrides a tag match.
    assign hit        = line_valid && (line_tag == pc_tag) && !flush;
    assign beat       = rvalid && rready;
    assign last_idx   = (beat_cnt == LAST_IDX);
    assign beat_err   = (rresp != RESP_OKAY) || (rlast != last_idx);
    assign err_now    = err || (beat && beat_err);
    // Beats past the last slot (missing rlast) are drained, not stored.
    assign wr_en      = beat && !overrun;
    assign bypass     = wr_en && (beat_cnt == pc_idx);
    assign burst_done = beat && rlast;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next (no latch).
        state_next = state;
        case (state)
            ST_BOOT:   state_next = ST_LOOKUP;
            ST_IDLE:   if (req_valid) state_next = ST_LOOKUP;
            ST_LOOKUP: state_next = hit ? ST_RESP : ST_AR;
            ST_AR:     if (arready) state_next = ST_R;
            ST_R:      if (burst_done) state_next = ST_RESP;
            ST_RESP:   if (out_ready) state_next = ST_IDLE;
            default:   state_next = ST_BOOT;
        endcase
    end

    always_comb begin
        req_ready = (state == ST_IDLE);
        arvalid   = (state == ST_AR);
        rready    = (state == ST_R);
        out_valid = (state == ST_RESP);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc            <= RESET_PC;
            araddr        <= 32'd0;
            beat_cnt      <= '0;
            err           <= 1'b0;
            flush_pending <= 1'b0;
            overrun       <= 1'b0;
            out_inst      <= 32'd0;
            out_pc        <= 32'd0;
            out_err       <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: pc <= RESET_PC;
                ST_IDLE: if (req_valid) pc <= req_pc;
                ST_LOOKUP: begin
                    out_pc <= pc;
                    if (hit) begin
                        out_inst <= rd_data;
                        out_err  <= 1'b0;
                    end else begin
                        araddr <= {pc[31:OFF_W], {OFF_W{1'b0}}};
                    end
                end
                ST_AR: begin
                    if (arready) begin
                        beat_cnt      <= '0;
                        err           <= 1'b0;
                        flush_pending <= 1'b0;
                        overrun       <= 1'b0;
                    end
                end
                ST_R: begin
                    if (flush) flush_pending <= 1'b1;
                    if (beat) begin
                        err <= err_now;
                        if (!last_idx) beat_cnt <= beat_cnt + IDX_W'(1);
                        if (last_idx && !rlast) overrun <= 1'b1;
                        if (rlast) begin
                            out_inst <= bypass ? rdata : rd_data;
                            out_err  <= err_now;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    ysyx_ifu_linebuf_mem #(
        .LINE_WORDS (LINE_WORDS)
    ) u_mem (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_idx     (beat_cnt),
        .wr_data    (rdata),
        .rd_idx     (pc_idx),
        .rd_data    (rd_data),
        .meta_we    (burst_done),
        .meta_valid (!err_now && !flush_pending && !flush),
        .meta_tag   (pc_tag),
        .inval      (flush && (state != ST_R)),
        .line_valid (line_valid),
        .line_tag   (line_tag)
    );

endmodule
